// File: rtl/mysystem_capture_ctrl.sv
// mysystem_capture_ctrl
//   Avalon-MM controlled capture sequencer. Software programs a frame count
//   (FRAMES) and a per-frame timeout (TIMEOUT), then writes GO. The block
//   waits for a frame-sync rising edge, issues a one-cycle start pulse to the
//   pipeline, then waits for the pipeline done pulse. This repeats until the
//   frame count is reached, or forever in continuous mode.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address[1:0]          0 CONTROL, 1 STATUS, 2 FRAMES, 3 TIMEOUT
//   chipselect, write_n   write accepted when chipselect=1 and write_n=0
//   writedata[31:0]       write data
//   readdata[31:0]        combinational read mux, zero wait states
//   vs_in                 frame sync (already synchronous to clk)
//   done_in               pipeline frame-complete pulse
//   start_out             one-cycle start pulse to the pipeline
//   irq                   level interrupt, irq_en & (done_flag | to_flag)
module mysystem_capture_ctrl #(
  parameter int unsigned TO_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        vs_in,
  input  logic        done_in,
  output logic        start_out,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, ARM, START, RUN} state_t;

  state_t            state, state_nxt;
  logic              vs_d;
  logic              cont, irq_en;
  logic              done_flag, to_flag;
  logic [15:0]       frame_cnt;
  logic [15:0]       frames;
  logic [TO_W-1:0]   timeout;
  logic [TO_W-1:0]   to_cnt;

  logic              wr_en, ctrl_wr, status_wr;
  logic              go_wr, abort_wr;
  logic              vs_rise;
  logic [15:0]       frame_cnt_inc;
  logic [15:0]       target_eff;
  logic              to_expired;
  logic              clr_run, cnt_inc, done_set, to_set, to_clr, to_inc;
  logic              unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en & (address == 2'd0);
  assign status_wr = wr_en & (address == 2'd1);
  assign go_wr     = ctrl_wr & writedata[0];
  assign abort_wr  = ctrl_wr & writedata[3];

  assign vs_rise       = vs_in & ~vs_d;
  assign frame_cnt_inc = frame_cnt + 16'd1;
  assign target_eff    = (frames == '0) ? 16'd1 : frames;
  assign to_expired    = (timeout != '0) && (to_cnt == timeout - TO_W'(1));

  // Decoded from the state register, so reset removes the pulse at once.
  assign start_out = (state == START);
  assign irq       = irq_en & (done_flag | to_flag);

  // Only part of the write bus maps onto register fields.
  assign unused_wd = ^writedata;

  always_comb begin
    state_nxt = state;
    clr_run   = 1'b0;
    cnt_inc   = 1'b0;
    done_set  = 1'b0;
    to_set    = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    // ABORT overrides everything, including a same-cycle done or timeout:
    // flags and frame_cnt stay exactly as they were.
    if (abort_wr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (go_wr) begin
            state_nxt = ARM;
            clr_run   = 1'b1;
          end
        end
        ARM: begin
          if (vs_rise) state_nxt = START;
        end
        START: begin
          state_nxt = RUN;
          to_clr    = 1'b1;
        end
        RUN: begin
          // done_in takes priority over a timeout expiring on the same cycle.
          if (done_in) begin
            cnt_inc = 1'b1;
            if ((frame_cnt_inc == target_eff) && !cont) begin
              state_nxt = IDLE;
              done_set  = 1'b1;
            end else begin
              state_nxt = ARM;
            end
          end else if (to_expired) begin
            state_nxt = IDLE;
            to_set    = 1'b1;
          end else begin
            to_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vs_d      <= 1'b0;
      cont      <= 1'b0;
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
      to_flag   <= 1'b0;
      frame_cnt <= '0;
      frames    <= 16'd1;
      timeout   <= '0;
      to_cnt    <= '0;
    end else begin
      state <= state_nxt;
      vs_d  <= vs_in;
      if (ctrl_wr) begin
        cont   <= writedata[1];
        irq_en <= writedata[2];
      end
      if (wr_en && (address == 2'd2)) frames  <= writedata[15:0];
      if (wr_en && (address == 2'd3)) timeout <= writedata[TO_W-1:0];
      if (clr_run) begin
        frame_cnt <= '0;
        done_flag <= 1'b0;
        to_flag   <= 1'b0;
      end else begin
        if (cnt_inc) frame_cnt <= frame_cnt_inc;
        // Hardware set beats a same-cycle W1C clear.
        if (done_set)                         done_flag <= 1'b1;
        else if (status_wr && writedata[1])   done_flag <= 1'b0;
        if (to_set)                           to_flag   <= 1'b1;
        else if (status_wr && writedata[2])   to_flag   <= 1'b0;
      end
      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[2:1] = {irq_en, cont};
      2'd1: begin
        readdata[0]     = (state != IDLE);
        readdata[1]     = done_flag;
        readdata[2]     = to_flag;
        readdata[31:16] = frame_cnt;
      end
      2'd2: readdata[15:0] = frames;
      default: readdata[TO_W-1:0] = timeout;
    endcase
  end

endmodule

// File: tb/tb_mysystem_capture_ctrl.sv
module tb_mysystem_capture_ctrl;

  localparam int unsigned TO_W = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        vs_in;
  logic        done_in;
  logic        start_out;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Start pulse monitor: number of sampled high cycles, and how many of them
  // continued a pulse from the previous cycle (should never happen).
  int   start_cnt = 0;
  int   wide_pulses = 0;
  logic start_prev = 1'b0;

  mysystem_capture_ctrl #(.TO_W(TO_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .vs_in      (vs_in),
    .done_in    (done_in),
    .start_out  (start_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_out === 1'b1) begin
      start_cnt++;
      if (start_prev === 1'b1) wide_pulses++;
    end
    start_prev = start_out;
  end

  // Expected STATUS word built from its field meanings.
  function automatic logic [31:0] exp_status(input int cnt, input bit to_f,
                                             input bit done_f, input bit busy);
    logic [15:0] c;
    c = 16'(cnt);
    return {c, 13'd0, to_f, done_f, busy};
  endfunction

  // Bus write: driven at a falling edge, accepted at the following rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Combinational read, sampled mid-cycle.
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  // One frame from ARM: optional ignored done in ARM, vs rise, optional
  // ignored vs rise in RUN, then done after dly cycles. Returns start_out
  // sampled in the cycle after the vs edge and in the cycle after that.
  task automatic run_frame(input int dly, input bit noise,
                           output logic s1, output logic s2);
    if (noise) begin
      done_in = 1'b1; @(negedge clk); done_in = 1'b0;
    end
    vs_in = 1'b1; @(negedge clk); s1 = start_out;
    vs_in = 1'b0; @(negedge clk); s2 = start_out;
    if (noise) begin
      vs_in = 1'b1; @(negedge clk); vs_in = 1'b0;
    end
    repeat (dly) @(negedge clk);
    done_in = 1'b1; @(negedge clk); done_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      logic [31:0] e;
      e = (a == 2) ? 32'h1 : 32'h0;
      rd(2'(a), r);
      checks++;
      if (r !== e) begin failures++; $display("FAIL reset_read%0d: got %h expected %h", a, r, e); end
    end
    checks++;
    if (start_out !== 1'b0) begin failures++; $display("FAIL reset_start: got %b expected 0", start_out); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_frames();
    logic [31:0] r;
    logic s1, s2;
    int n, base;
    n = $urandom_range(2, 5);
    wr(2'd2, 32'(n));
    wr(2'd3, 32'h0);
    base = start_cnt;
    wr(2'd0, 32'h5);
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(0, 0, 0, 1)) begin failures++; $display("FAIL frames_busy: got %h expected %h", r, exp_status(0, 0, 0, 1)); end
    for (int i = 0; i < n; i++) begin
      run_frame($urandom_range(1, 10), 1'($urandom_range(0, 1)), s1, s2);
      checks++;
      if (s1 !== 1'b1 || s2 !== 1'b0) begin failures++; $display("FAIL frames_pulse%0d: got %b%b expected 10", i, s1, s2); end
      if (i < n - 1) begin
        rd(2'd1, r);
        checks++;
        if (r !== exp_status(i + 1, 0, 0, 1)) begin failures++; $display("FAIL frames_mid%0d: got %h expected %h", i, r, exp_status(i + 1, 0, 0, 1)); end
      end
    end
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(n, 0, 1, 0)) begin failures++; $display("FAIL frames_done: got %h expected %h", r, exp_status(n, 0, 1, 0)); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL frames_irq: got %b expected 1", irq); end
    checks++;
    if (start_cnt - base !== n || wide_pulses !== 0) begin
      failures++; $display("FAIL frames_count: got %0d pulses (%0d wide) expected %0d", start_cnt - base, wide_pulses, n);
    end
    wr(2'd1, 32'h2);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL frames_w1c_irq: got %b expected 0", irq); end
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(n, 0, 0, 0)) begin failures++; $display("FAIL frames_w1c: got %h expected %h", r, exp_status(n, 0, 0, 0)); end
  endtask

  task automatic test_frames_zero();
    logic [31:0] r;
    logic s1, s2;
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h1);
    run_frame(2, 1'b0, s1, s2);
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(1, 0, 1, 0)) begin failures++; $display("FAIL zero_target: got %h expected %h", r, exp_status(1, 0, 1, 0)); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL zero_irq_masked: got %b expected 0", irq); end
    wr(2'd1, 32'h2);
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    int t;
    for (int pass = 0; pass < 2; pass++) begin
      t = (pass == 0) ? 20 : $urandom_range(3, 30);
      wr(2'd2, 32'h1);
      wr(2'd3, 32'(t));
      wr(2'd0, 32'h5);
      // Expiry without done: flag appears T cycles after RUN entry.
      vs_in = 1'b1; @(negedge clk); vs_in = 1'b0;
      repeat (t) @(negedge clk);
      rd(2'd1, r);
      checks++;
      if (r !== exp_status(0, 0, 0, 1)) begin failures++; $display("FAIL to_early%0d: got %h expected %h", t, r, exp_status(0, 0, 0, 1)); end
      @(negedge clk);
      rd(2'd1, r);
      checks++;
      if (r !== exp_status(0, 1, 0, 0)) begin failures++; $display("FAIL to_fire%0d: got %h expected %h", t, r, exp_status(0, 1, 0, 0)); end
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL to_irq%0d: got %b expected 1", t, irq); end
      wr(2'd1, 32'h4);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL to_w1c%0d: got %b expected 0", t, irq); end
      // done_in on the expiry cycle wins.
      wr(2'd0, 32'h5);
      vs_in = 1'b1; @(negedge clk); vs_in = 1'b0;
      repeat (t) @(negedge clk);
      done_in = 1'b1; @(negedge clk); done_in = 1'b0;
      rd(2'd1, r);
      checks++;
      if (r !== exp_status(1, 0, 1, 0)) begin failures++; $display("FAIL to_done_wins%0d: got %h expected %h", t, r, exp_status(1, 0, 1, 0)); end
      wr(2'd1, 32'h2);
    end
    wr(2'd3, 32'h0);
  endtask

  task automatic test_cont();
    logic [31:0] r;
    logic s1, s2;
    int n;
    n = $urandom_range(3, 6);
    wr(2'd2, 32'h2);
    wr(2'd0, 32'h3);
    for (int i = 0; i < n; i++) begin
      run_frame($urandom_range(1, 6), 1'b0, s1, s2);
      rd(2'd1, r);
      checks++;
      if (r !== exp_status(i + 1, 0, 0, 1)) begin failures++; $display("FAIL cont_frame%0d: got %h expected %h", i, r, exp_status(i + 1, 0, 0, 1)); end
    end
    wr(2'd0, 32'h8);
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(n, 0, 0, 0)) begin failures++; $display("FAIL cont_abort: got %h expected %h", r, exp_status(n, 0, 0, 0)); end
  endtask

  task automatic test_go_busy();
    logic [31:0] r;
    logic s1, s2;
    int base;
    wr(2'd2, 32'h3);
    wr(2'd0, 32'h1);
    run_frame(3, 1'b0, s1, s2);
    vs_in = 1'b1; @(negedge clk); vs_in = 1'b0; @(negedge clk);
    base = start_cnt;
    wr(2'd0, 32'h1);
    repeat (4) @(negedge clk);
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(1, 0, 0, 1)) begin failures++; $display("FAIL go_busy_status: got %h expected %h", r, exp_status(1, 0, 0, 1)); end
    checks++;
    if (start_cnt !== base) begin failures++; $display("FAIL go_busy_start: got %0d expected %0d", start_cnt, base); end
    wr(2'd0, 32'h8);
    wr(2'd0, 32'h9);
    repeat (2) @(negedge clk);
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(1, 0, 0, 0)) begin failures++; $display("FAIL go_abort: got %h expected %h", r, exp_status(1, 0, 0, 0)); end
  endtask

  task automatic test_set_wins();
    logic [31:0] r;
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h1);
    vs_in = 1'b1; @(negedge clk); vs_in = 1'b0; @(negedge clk);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    done_in = 1'b1;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h6;
    @(negedge clk);
    done_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    rd(2'd1, r);
    checks++;
    if (r !== exp_status(1, 0, 1, 0)) begin failures++; $display("FAIL set_wins: got %h expected %h", r, exp_status(1, 0, 1, 0)); end
    wr(2'd1, 32'h2);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r;
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h7);
    wr(2'd0, 32'h7);
    vs_in = 1'b1; @(negedge clk); vs_in = 1'b0;
    checks++;
    if (start_out !== 1'b1) begin failures++; $display("FAIL rst_pre_start: got %b expected 1", start_out); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (start_out !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL rst_async: got start=%b irq=%b expected 0 0", start_out, irq); end
    for (int a = 0; a < 4; a++) begin
      logic [31:0] e;
      e = (a == 2) ? 32'h1 : 32'h0;
      rd(2'(a), r);
      checks++;
      if (r !== e) begin failures++; $display("FAIL rst_read%0d: got %h expected %h", a, r, e); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL rst_after: got %h expected 00000000", r); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; vs_in = 1'b0; done_in = 1'b0;
    test_reset();
    test_frames();
    test_frames_zero();
    test_timeout();
    test_cont();
    test_go_busy();
    test_set_wins();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
